// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the multicore memory system: the data word, the RAM
// status encoding, the coherence arbiter state encoding and the default
// number of cores.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int CPUS_DEFAULT = 2;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNOOP  = 3'd1,
        C2C    = 3'd2,
        MEMRD  = 3'd3,
        MEMWB  = 3'd4,
        IFETCH = 3'd5
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin pick over an N-wide request vector. The search starts at the
// pointer, which sits one past the most recently completed grant.
// Ports:
//   CLK, nRST  clock and asynchronous active-low reset
//   req        request vector
//   advance    strobe: the transaction for done_idx has completed
//   done_idx   index of the completed grant (pointer moves past it)
//   grant      index of the chosen requester (valid when any is high)
//   any        at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int N  = CPUS_DEFAULT,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] done_idx,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [IW-1:0] ptr;
    int            idx;

    // Pointer moves only when the owner's transaction is acknowledged, so a
    // stalled transaction keeps its place in the rotation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (advance) begin
            if (int'(done_idx) >= N - 1) begin
                ptr <= '0;
            end else begin
                ptr <= IW'(int'(done_idx) + 1);
            end
        end
    end

    // First requester found walking forward from the pointer, with wrap.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/coherence_arbiter.sv
// ---------------------------------------------------------------------------
// coherence_arbiter
// Shares one RAM port between CPUS cores (icache + dcache each) and runs a
// snoop for every dcache read so a modified copy in another core is
// forwarded cache-to-cache and written back at the same time.
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   iREN/iaddr -> iwait/iload       icache request and response per core
//   dREN/dWEN/daddr/dstore          dcache request, address, write data
//   ccwrite/cctrans                 requester coherence intent/status
//   dwait/dload                     dcache response per core
//   ccwait/ccinv/ccsnoopaddr        snoop command to the other cores
//   ramstate/ramload                RAM status and read data
//   ramREN/ramWEN/ramaddr/ramstore  RAM command
// ---------------------------------------------------------------------------
module coherence_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = CPUS_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    input  ramstate_t            ramstate,
    input  logic [31:0]          ramload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t    state, next_state;
    logic [IW-1:0] owner_d, owner_i, snooper;
    logic [IW-1:0] d_grant, i_grant, snoop_idx;
    logic          d_any, i_any, snoop_hit;
    logic          ram_ack, d_adv, i_adv;

    // The requester's transition status does not influence arbitration.
    logic          unused_cctrans;
    assign unused_cctrans = ^cctrans;

    assign ram_ack = (ramstate == ACCESS);
    assign d_adv   = ram_ack && (state == C2C || state == MEMRD || state == MEMWB);
    assign i_adv   = ram_ack && (state == IFETCH);

    rr_arbiter #(.N(CPUS), .IW(IW)) u_darb (
        .CLK(CLK), .nRST(nRST), .req(dREN | dWEN), .advance(d_adv),
        .done_idx(owner_d), .grant(d_grant), .any(d_any)
    );

    rr_arbiter #(.N(CPUS), .IW(IW)) u_iarb (
        .CLK(CLK), .nRST(nRST), .req(iREN), .advance(i_adv),
        .done_idx(owner_i), .grant(i_grant), .any(i_any)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Owners are latched at the decision point so that a request dropped
    // mid-transaction still completes toward the core that was granted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner_d <= '0;
            owner_i <= '0;
            snooper <= '0;
        end else begin
            if (state == IDLE) begin
                if (d_any) begin
                    owner_d <= d_grant;
                end else if (i_any) begin
                    owner_i <= i_grant;
                end
            end
            if (state == SNOOP) begin
                snooper <= snoop_idx;
            end
        end
    end

    // Next state. A snooped core holding a modified copy answers by raising
    // its own dWEN during SNOOP; the lowest such core supplies the data.
    always_comb begin
        next_state = state;
        snoop_hit  = 1'b0;
        snoop_idx  = '0;
        for (int j = 0; j < CPUS; j++) begin
            if (IW'(j) != owner_d && dWEN[j] && !snoop_hit) begin
                snoop_hit = 1'b1;
                snoop_idx = IW'(j);
            end
        end
        case (state)
            IDLE: begin
                if (d_any) begin
                    next_state = dWEN[d_grant] ? MEMWB : SNOOP;
                end else if (i_any) begin
                    next_state = IFETCH;
                end
            end
            SNOOP: next_state = snoop_hit ? C2C : MEMRD;
            C2C, MEMRD, MEMWB, IFETCH: begin
                if (ram_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs. Strobes depend only on state so BUSY/FREE/ERROR hold them
    // steady; the wait releases are gated by the ACCESS acknowledgement.
    always_comb begin
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        dwait       = '1;
        iwait       = '1;
        dload       = '0;
        iload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        if (state == SNOOP || state == C2C || state == MEMRD) begin
            for (int j = 0; j < CPUS; j++) begin
                if (IW'(j) != owner_d) begin
                    ccwait[j]      = 1'b1;
                    ccinv[j]       = ccwrite[owner_d];
                    ccsnoopaddr[j] = daddr[owner_d];
                end
            end
        end
        case (state)
            C2C: begin
                ramWEN         = 1'b1;
                ramaddr        = daddr[snooper];
                ramstore       = dstore[snooper];
                dload[owner_d] = dstore[snooper];
                if (ram_ack) begin
                    dwait[owner_d] = 1'b0;
                    dwait[snooper] = 1'b0;
                end
            end
            MEMRD: begin
                ramREN         = 1'b1;
                ramaddr        = daddr[owner_d];
                dload[owner_d] = ramload;
                if (ram_ack) begin
                    dwait[owner_d] = 1'b0;
                end
            end
            MEMWB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[owner_d];
                ramstore = dstore[owner_d];
                if (ram_ack) begin
                    dwait[owner_d] = 1'b0;
                end
            end
            IFETCH: begin
                ramREN         = 1'b1;
                ramaddr        = iaddr[owner_i];
                iload[owner_i] = ramload;
                if (ram_ack) begin
                    iwait[owner_i] = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_coherence_arbiter.sv
// ---------------------------------------------------------------------------
// tb_coherence_arbiter
// Directed bench for coherence_arbiter with two cores and a simple RAM
// model: ramload = ramaddr + 0x10000000, ramstate is ACCESS whenever a
// strobe is up unless the bench forces a stall (BUSY).
// ---------------------------------------------------------------------------
module tb_coherence_arbiter;
    import cpu_types_pkg::*;

    logic             CLK;
    logic             nRST;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0]       ccwrite;
    logic [1:0]       cctrans;
    logic [1:0]       dwait;
    logic [1:0][31:0] dload;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    ramstate_t        ramstate;
    logic [31:0]      ramload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;

    logic             stall;
    logic [31:0]      lastWaddr;
    logic [31:0]      lastWdata;
    int               checks;
    int               errors;

    typedef struct {
        int          core;
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          expLat;
        logic        expRen;
        logic        expWen;
        logic [31:0] expBus;
    } vec_t;

    vec_t vecs[6];

    coherence_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: answers immediately unless stalled.
    assign ramstate = (ramREN || ramWEN) ? (stall ? BUSY : ACCESS) : FREE;
    assign ramload  = ramaddr + 32'h1000_0000;

    // Remember the last write the RAM actually accepted.
    always @(posedge CLK) begin
        if (ramWEN && ramstate == ACCESS) begin
            lastWaddr <= ramaddr;
            lastWdata <= ramstore;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0;
        daddr = '0; dstore = '0; ccwrite = '0; cctrans = '0;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench one tick into the first cycle with nRST high.
    task automatic doReset();
        nextCycle();
        nRST = 1'b0;
        stall = 1'b0;
        clearInputs();
        nextCycle();
        nRST = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearInputs();
        case (v.kind)
            0: begin dWEN[v.core] = 1'b1; daddr[v.core] = v.addr; dstore[v.core] = v.data; end
            1: begin dREN[v.core] = 1'b1; daddr[v.core] = v.addr; end
            default: begin iREN[v.core] = 1'b1; iaddr[v.core] = v.addr; end
        endcase
    endtask

    function automatic logic waitOf(input int kind, input int core);
        return (kind == 2) ? iwait[core] : dwait[core];
    endfunction

    function automatic logic [31:0] busOf(input int kind, input int core);
        if (kind == 0) return ramstore;
        if (kind == 1) return dload[core];
        return iload[core];
    endfunction

    initial begin
        int          lat;
        logic        capRen, capWen, capOther;
        logic [31:0] capBus, capAddr;
        int          grants[4];
        int          nGrants;
        int          dFirst, iFirst;
        logic [31:0] iLoadSeen;

        checks = 0;
        errors = 0;
        stall  = 1'b0;
        clearInputs();
        nRST = 1'b0;

        // kind: 0 = dcache write, 1 = dcache read, 2 = icache read
        vecs[0] = '{0, 0, 32'h0000_0040, 32'h1111_2222, 2, 1'b0, 1'b1, 32'h1111_2222};
        vecs[1] = '{1, 0, 32'h0000_0044, 32'h3333_4444, 2, 1'b0, 1'b1, 32'h3333_4444};
        vecs[2] = '{0, 1, 32'h0000_0100, 32'h0,         3, 1'b1, 1'b0, 32'h1000_0100};
        vecs[3] = '{1, 1, 32'h0000_0104, 32'h0,         3, 1'b1, 1'b0, 32'h1000_0104};
        vecs[4] = '{0, 2, 32'h0000_0200, 32'h0,         2, 1'b1, 1'b0, 32'h1000_0200};
        vecs[5] = '{1, 2, 32'h0000_0300, 32'h0,         2, 1'b1, 1'b0, 32'h1000_0300};

        // Reset values while nRST is held low.
        #2;
        checkOutput("reset dwait", {30'd0, dwait}, 32'h3);
        checkOutput("reset iwait", {30'd0, iwait}, 32'h3);
        checkOutput("reset strobes", {30'd0, ramREN, ramWEN}, 32'h0);
        checkOutput("reset ramaddr", ramaddr, 32'h0);
        checkOutput("reset ccwait", {30'd0, ccwait}, 32'h0);
        checkOutput("reset dload0", dload[0], 32'h0);

        $display("[TB] single-transaction vectors");
        for (int v = 0; v < 6; v++) begin
            doReset();
            applyStimulus(vecs[v]);
            #1;
            lat = 0;
            capRen = 1'b0; capWen = 1'b0; capBus = '0; capAddr = '0; capOther = 1'b0;
            for (int c = 1; c <= 10 && lat == 0; c++) begin
                if (c > 1) begin
                    nextCycle();
                    #1;
                end
                if (!waitOf(vecs[v].kind, vecs[v].core)) begin
                    lat      = c;
                    capRen   = ramREN;
                    capWen   = ramWEN;
                    capAddr  = ramaddr;
                    capBus   = busOf(vecs[v].kind, vecs[v].core);
                    capOther = waitOf(vecs[v].kind, 1 - vecs[v].core);
                end
            end
            checkOutput($sformatf("vec%0d latency", v), lat, vecs[v].expLat);
            checkOutput($sformatf("vec%0d strobes", v), {30'd0, capRen, capWen},
                        {30'd0, vecs[v].expRen, vecs[v].expWen});
            checkOutput($sformatf("vec%0d ramaddr", v), capAddr, vecs[v].addr);
            checkOutput($sformatf("vec%0d data", v), capBus, vecs[v].expBus);
            checkOutput($sformatf("vec%0d other wait", v), {31'd0, capOther}, 32'h1);
            nextCycle();
            clearInputs();
            #1;
            checkOutput($sformatf("vec%0d back idle", v), {30'd0, ramREN, ramWEN}, 32'h0);
        end

        $display("[TB] read miss with snoop");
        doReset();
        dREN[0] = 1'b1; daddr[0] = 32'h100;
        #1;
        nextCycle(); #1;
        checkOutput("snoop ccwait", {30'd0, ccwait}, 32'h2);
        checkOutput("snoop addr1", ccsnoopaddr[1], 32'h100);
        checkOutput("snoop ccinv", {30'd0, ccinv}, 32'h0);
        checkOutput("snoop dwait", {30'd0, dwait}, 32'h3);
        nextCycle(); #1;
        checkOutput("memrd ccwait", {30'd0, ccwait}, 32'h2);
        checkOutput("memrd dwait", {30'd0, dwait}, 32'h2);
        checkOutput("memrd dload0", dload[0], 32'h1000_0100);
        nextCycle(); clearInputs(); #1;
        checkOutput("memrd ccwait released", {30'd0, ccwait}, 32'h0);

        $display("[TB] cache-to-cache transfer");
        doReset();
        dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h200;
        #1;
        nextCycle(); #1;
        checkOutput("c2c ccinv", {30'd0, ccinv}, 32'h2);
        checkOutput("c2c snoop addr", ccsnoopaddr[1], 32'h200);
        dWEN[1] = 1'b1; dstore[1] = 32'hDEAD_BEEF; daddr[1] = 32'h200;
        #1;
        nextCycle(); #1;
        checkOutput("c2c strobes", {30'd0, ramREN, ramWEN}, 32'h1);
        checkOutput("c2c ramaddr", ramaddr, 32'h200);
        checkOutput("c2c ramstore", ramstore, 32'hDEAD_BEEF);
        checkOutput("c2c dload0", dload[0], 32'hDEAD_BEEF);
        checkOutput("c2c dwait", {30'd0, dwait}, 32'h0);
        checkOutput("c2c ccwait", {30'd0, ccwait}, 32'h2);
        nextCycle(); clearInputs(); #1;
        checkOutput("c2c written addr", lastWaddr, 32'h200);
        checkOutput("c2c written data", lastWdata, 32'hDEAD_BEEF);
        checkOutput("c2c after dwait", {30'd0, dwait}, 32'h3);

        $display("[TB] round-robin between dcache readers");
        doReset();
        dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h14;
        #1;
        nGrants = 0;
        for (int c = 1; c <= 30 && nGrants < 4; c++) begin
            if (c > 1) begin
                nextCycle();
                #1;
            end
            if (dwait == 2'b10 || dwait == 2'b01) begin
                grants[nGrants] = (dwait == 2'b10) ? 0 : 1;
                nGrants++;
            end else if (dwait == 2'b00) begin
                checkOutput("rr both released", {30'd0, dwait}, 32'h3);
            end
        end
        checkOutput("rr grant count", nGrants, 4);
        for (int g = 0; g < 4; g++) begin
            checkOutput($sformatf("rr grant%0d", g), (g < nGrants) ? grants[g] : -1, g % 2);
        end
        nextCycle(); clearInputs();

        $display("[TB] dcache over icache");
        doReset();
        iREN[0] = 1'b1; iaddr[0] = 32'h400;
        dREN[1] = 1'b1; daddr[1] = 32'h500;
        #1;
        dFirst = 0; iFirst = 0; iLoadSeen = '0;
        for (int c = 1; c <= 20 && iFirst == 0; c++) begin
            if (c > 1) begin
                nextCycle();
                if (dFirst != 0) dREN[1] = 1'b0;
                #1;
            end
            if (!dwait[1] && dFirst == 0) dFirst = c;
            if (!iwait[0] && iFirst == 0) begin
                iFirst    = c;
                iLoadSeen = iload[0];
            end
        end
        checkOutput("prio dcache cycle", dFirst, 3);
        checkOutput("prio icache cycle", iFirst, 5);
        checkOutput("prio iload0", iLoadSeen, 32'h1000_0400);
        nextCycle(); clearInputs();

        $display("[TB] writeback with busy RAM");
        doReset();
        stall = 1'b1;
        dWEN[0] = 1'b1; daddr[0] = 32'h80; dstore[0] = 32'h55AA_55AA;
        #1;
        for (int b = 0; b < 5; b++) begin
            nextCycle(); #1;
            checkOutput($sformatf("busy%0d strobes", b), {30'd0, ramREN, ramWEN}, 32'h1);
            checkOutput($sformatf("busy%0d ramaddr", b), ramaddr, 32'h80);
            checkOutput($sformatf("busy%0d ramstore", b), ramstore, 32'h55AA_55AA);
            checkOutput($sformatf("busy%0d dwait", b), {30'd0, dwait}, 32'h3);
        end
        nextCycle();
        stall = 1'b0;
        #1;
        checkOutput("busy access dwait", {30'd0, dwait}, 32'h2);
        nextCycle(); clearInputs(); #1;
        checkOutput("busy after dwait", {30'd0, dwait}, 32'h3);
        checkOutput("busy written data", lastWdata, 32'h55AA_55AA);

        $display("[TB] reset during cache-to-cache");
        doReset();
        stall = 1'b1;
        dREN[0] = 1'b1; daddr[0] = 32'h600;
        #1;
        nextCycle();
        dWEN[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'h1234_5678;
        #1;
        nextCycle(); #1;
        checkOutput("rst in c2c", {30'd0, ramREN, ramWEN}, 32'h1);
        nRST = 1'b0;
        #1;
        checkOutput("rst strobes", {30'd0, ramREN, ramWEN}, 32'h0);
        checkOutput("rst ramaddr", ramaddr, 32'h0);
        checkOutput("rst ramstore", ramstore, 32'h0);
        checkOutput("rst dwait", {30'd0, dwait}, 32'h3);
        checkOutput("rst iwait", {30'd0, iwait}, 32'h3);
        checkOutput("rst cc", {28'd0, ccwait, ccinv}, 32'h0);
        checkOutput("rst snoopaddr1", ccsnoopaddr[1], 32'h0);
        checkOutput("rst dload0", dload[0], 32'h0);
        stall = 1'b0;
        nextCycle(); #1;
        checkOutput("rst held dwait", {30'd0, dwait}, 32'h3);
        clearInputs();
        nRST = 1'b1;
        dWEN[1] = 1'b1; daddr[1] = 32'h60; dstore[1] = 32'hCAFE_F00D;
        #1;
        checkOutput("post rst idle dwait", {30'd0, dwait}, 32'h3);
        nextCycle(); #1;
        checkOutput("post rst dwait", {30'd0, dwait}, 32'h1);
        checkOutput("post rst ramaddr", ramaddr, 32'h60);
        checkOutput("post rst ramstore", ramstore, 32'hCAFE_F00D);
        nextCycle(); clearInputs(); #1;
        checkOutput("post rst written addr", lastWaddr, 32'h60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
